// File: rtl/evaluate_arbiter.sv
// Round-robin arbiter that shares one fixed-latency board evaluator between NUM_REQ requesters.
// Issues the winning board, waits for the result under a watchdog and returns it with a one-hot pulse.
module evaluate_arbiter #(
   parameter int EVAL_WIDTH     = 32,
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int BOARD_WIDTH    = 256
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*BOARD_WIDTH-1:0] req_board,
   input  logic [NUM_REQ-1:0]             req_white_to_move,
   output logic [NUM_REQ-1:0]             result_valid,
   output logic [EVAL_WIDTH-1:0]          result_mg,
   output logic [EVAL_WIDTH-1:0]          result_eg,
   output logic                           result_insufficient,
   output logic                           result_timeout,
   output logic                           busy,
   output logic [31:0]                    eval_count,
   output logic [BOARD_WIDTH-1:0]         ev_board,
   output logic                           ev_white_to_move,
   output logic                           ev_board_valid,
   output logic                           ev_clear_eval,
   input  logic [EVAL_WIDTH-1:0]          ev_eval_mg,
   input  logic [EVAL_WIDTH-1:0]          ev_eval_eg,
   input  logic                           ev_insufficient,
   input  logic                           ev_eval_valid
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CLEAR} state_t;

   state_t                  state_reg, state_next;
   logic [IDX_W-1:0]        rr_ptr_reg, rr_ptr_next;
   logic [IDX_W-1:0]        gnt_idx_reg, gnt_idx_next;
   logic [NUM_REQ-1:0]      armed_reg, armed_next;
   logic [WD_W-1:0]         wd_reg, wd_next;
   logic [31:0]             eval_count_reg, eval_count_next;
   logic [NUM_REQ-1:0]      result_valid_reg, result_valid_next;
   logic [EVAL_WIDTH-1:0]   result_mg_reg, result_mg_next;
   logic [EVAL_WIDTH-1:0]   result_eg_reg, result_eg_next;
   logic                    result_insufficient_reg, result_insufficient_next;
   logic                    result_timeout_reg, result_timeout_next;
   logic                    busy_reg, busy_next;
   logic [BOARD_WIDTH-1:0]  ev_board_reg, ev_board_next;
   logic                    ev_white_to_move_reg, ev_white_to_move_next;
   logic                    ev_board_valid_reg, ev_board_valid_next;
   logic                    ev_clear_eval_reg, ev_clear_eval_next;

   logic [NUM_REQ-1:0]      eligible;
   logic [BOARD_WIDTH-1:0]  board_arr [NUM_REQ];
   logic [IDX_W:0]          cand_sum  [NUM_REQ];
   logic [IDX_W:0]          cand_wrap [NUM_REQ];
   logic [IDX_W-1:0]        cand_idx  [NUM_REQ];
   logic [NUM_REQ-1:0]      cand_hit;
   logic [IDX_W-1:0]        win_idx;
   logic [NUM_REQ-1:0]      gnt_onehot;

   assign eligible   = req & armed_reg;
   assign gnt_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx_reg;

   // Candidate gi is the requester gi places after rr_ptr, wrapped into 0..NUM_REQ-1.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign board_arr[gi] = req_board[gi*BOARD_WIDTH +: BOARD_WIDTH];
      assign cand_sum[gi]  = {1'b0, rr_ptr_reg} + (IDX_W+1)'(gi);
      assign cand_wrap[gi] = (cand_sum[gi] >= NUM_REQ_W) ? (cand_sum[gi] - NUM_REQ_W) : cand_sum[gi];
      assign cand_idx[gi]  = cand_wrap[gi][IDX_W-1:0];
      assign cand_hit[gi]  = eligible[cand_idx[gi]];
   end

   always_comb begin
      win_idx = cand_idx[0];
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (cand_hit[k]) begin
            win_idx = cand_idx[k];
         end
      end
   end

   always_comb begin
      state_next               = state_reg;
      rr_ptr_next              = rr_ptr_reg;
      gnt_idx_next             = gnt_idx_reg;
      armed_next               = armed_reg | ~req;
      wd_next                  = wd_reg;
      eval_count_next          = eval_count_reg;
      result_valid_next        = '0;
      result_mg_next           = result_mg_reg;
      result_eg_next           = result_eg_reg;
      result_insufficient_next = result_insufficient_reg;
      result_timeout_next      = 1'b0;
      ev_board_next            = ev_board_reg;
      ev_white_to_move_next    = ev_white_to_move_reg;
      ev_board_valid_next      = 1'b0;
      ev_clear_eval_next       = 1'b0;

      case (state_reg)
         IDLE: begin
            if (|eligible) begin
               state_next            = ISSUE;
               gnt_idx_next          = win_idx;
               ev_board_next         = board_arr[win_idx];
               ev_white_to_move_next = req_white_to_move[win_idx];
               ev_board_valid_next   = 1'b1;
            end
         end
         ISSUE: begin
            state_next = WAIT;
            wd_next    = '0;
         end
         WAIT: begin
            // A valid result on the last watchdog cycle still counts as a normal result.
            if (ev_eval_valid) begin
               state_next               = CLEAR;
               result_valid_next        = gnt_onehot;
               result_mg_next           = ev_eval_mg;
               result_eg_next           = ev_eval_eg;
               result_insufficient_next = ev_insufficient;
               ev_clear_eval_next       = 1'b1;
               eval_count_next          = eval_count_reg + 32'd1;
               armed_next               = (armed_reg | ~req) & ~gnt_onehot;
            end else if (wd_reg == WD_LAST) begin
               state_next               = CLEAR;
               result_valid_next        = gnt_onehot;
               result_mg_next           = '0;
               result_eg_next           = '0;
               result_insufficient_next = 1'b0;
               result_timeout_next      = 1'b1;
               ev_clear_eval_next       = 1'b1;
               armed_next               = (armed_reg | ~req) & ~gnt_onehot;
            end else begin
               wd_next = wd_reg + 1'b1;
            end
         end
         CLEAR: begin
            state_next  = IDLE;
            rr_ptr_next = (gnt_idx_reg == LAST_IDX) ? '0 : gnt_idx_reg + 1'b1;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg               <= IDLE;
         rr_ptr_reg              <= '0;
         gnt_idx_reg             <= '0;
         armed_reg               <= '1;
         wd_reg                  <= '0;
         eval_count_reg          <= '0;
         result_valid_reg        <= '0;
         result_mg_reg           <= '0;
         result_eg_reg           <= '0;
         result_insufficient_reg <= 1'b0;
         result_timeout_reg      <= 1'b0;
         busy_reg                <= 1'b0;
         ev_board_reg            <= '0;
         ev_white_to_move_reg    <= 1'b0;
         ev_board_valid_reg      <= 1'b0;
         ev_clear_eval_reg       <= 1'b0;
      end else begin
         state_reg               <= state_next;
         rr_ptr_reg              <= rr_ptr_next;
         gnt_idx_reg             <= gnt_idx_next;
         armed_reg               <= armed_next;
         wd_reg                  <= wd_next;
         eval_count_reg          <= eval_count_next;
         result_valid_reg        <= result_valid_next;
         result_mg_reg           <= result_mg_next;
         result_eg_reg           <= result_eg_next;
         result_insufficient_reg <= result_insufficient_next;
         result_timeout_reg      <= result_timeout_next;
         busy_reg                <= busy_next;
         ev_board_reg            <= ev_board_next;
         ev_white_to_move_reg    <= ev_white_to_move_next;
         ev_board_valid_reg      <= ev_board_valid_next;
         ev_clear_eval_reg       <= ev_clear_eval_next;
      end
   end

   assign result_valid        = result_valid_reg;
   assign result_mg           = result_mg_reg;
   assign result_eg           = result_eg_reg;
   assign result_insufficient = result_insufficient_reg;
   assign result_timeout      = result_timeout_reg;
   assign busy                = busy_reg;
   assign eval_count          = eval_count_reg;
   assign ev_board            = ev_board_reg;
   assign ev_white_to_move    = ev_white_to_move_reg;
   assign ev_board_valid      = ev_board_valid_reg;
   assign ev_clear_eval       = ev_clear_eval_reg;

endmodule

// File: tb/tb_evaluate_arbiter.sv
// Bench for evaluate_arbiter: directed table of single evaluations, hand-written corner sequences
// and a randomized multi-requester run checked against a transaction-level model.
module tb_evaluate_arbiter;
   localparam int EW = 32;
   localparam int NR = 4;
   localparam int TO = 64;
   localparam int BW = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic [NR-1:0]    req;
   logic [NR*BW-1:0] req_board;
   logic [NR-1:0]    req_white_to_move;
   logic [NR-1:0]    result_valid;
   logic [EW-1:0]    result_mg, result_eg;
   logic             result_insufficient, result_timeout, busy;
   logic [31:0]      eval_count;
   logic [BW-1:0]    ev_board;
   logic             ev_white_to_move, ev_board_valid, ev_clear_eval;
   logic [EW-1:0]    ev_eval_mg, ev_eval_eg;
   logic             ev_insufficient, ev_eval_valid;

   always #5 clk = ~clk;

   evaluate_arbiter #(.EVAL_WIDTH(EW), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO), .BOARD_WIDTH(BW)) dut (
      .clk(clk), .reset(reset), .req(req), .req_board(req_board),
      .req_white_to_move(req_white_to_move), .result_valid(result_valid),
      .result_mg(result_mg), .result_eg(result_eg), .result_insufficient(result_insufficient),
      .result_timeout(result_timeout), .busy(busy), .eval_count(eval_count),
      .ev_board(ev_board), .ev_white_to_move(ev_white_to_move), .ev_board_valid(ev_board_valid),
      .ev_clear_eval(ev_clear_eval), .ev_eval_mg(ev_eval_mg), .ev_eval_eg(ev_eval_eg),
      .ev_insufficient(ev_insufficient), .ev_eval_valid(ev_eval_valid));

   // Stub evaluator: valid rises stub_lat cycles after the board_valid cycle and holds until clear.
   int   stub_lat = 7;
   bit   stub_fixed = 1'b1;
   bit   stub_kill = 1'b0;
   logic stub_valid = 1'b0;
   bit   stub_pend = 1'b0;
   int   stub_cnt = 0;

   always @(posedge clk) begin
      if (stub_kill || ev_clear_eval) begin
         stub_valid <= 1'b0;
         stub_pend  <= 1'b0;
         stub_cnt   <= 0;
      end else if (ev_board_valid) begin
         stub_pend  <= (stub_lat != 1);
         stub_valid <= (stub_lat == 1);
         stub_cnt   <= 1;
      end else if (stub_pend) begin
         stub_cnt <= stub_cnt + 1;
         if (stub_lat != 0 && stub_cnt + 1 == stub_lat) begin
            stub_valid <= 1'b1;
            stub_pend  <= 1'b0;
         end
      end
   end

   assign ev_eval_valid   = stub_valid;
   assign ev_eval_mg      = stub_fixed ? 32'd100 : 32'(int'({16'd0, ev_board}) - 30000);
   assign ev_eval_eg      = stub_fixed ? 32'(-50) : 32'(0 - int'({16'd0, ev_board}));
   assign ev_insufficient = stub_fixed ? 1'b0 : ev_board[0];

   int vectors = 0;
   int miscompares = 0;
   int exp_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_result_valid"}, 32'(result_valid), 32'd0);
      check({tag, "_mg"}, result_mg, 32'd0);
      check({tag, "_eg"}, result_eg, 32'd0);
      check({tag, "_insuf"}, 32'(result_insufficient), 32'd0);
      check({tag, "_timeout"}, 32'(result_timeout), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_eval_count"}, eval_count, 32'd0);
      check({tag, "_ev_board"}, 32'(ev_board), 32'd0);
      check({tag, "_ev_wtm"}, 32'(ev_white_to_move), 32'd0);
      check({tag, "_ev_board_valid"}, 32'(ev_board_valid), 32'd0);
      check({tag, "_ev_clear"}, 32'(ev_clear_eval), 32'd0);
   endtask

   typedef struct {
      logic [NR-1:0] mask;
      int            lat;      // 0 = evaluator never answers
      logic [NR-1:0] exp_oh;
      int            exp_tick; // cycles from request to result pulse
      bit            exp_to;
   } vec_t;

   vec_t tbl[8];

   function automatic logic [BW-1:0] dir_board(input int i);
      return 16'hA000 | 16'(i * 16'h0111);
   endfunction

   task automatic run_vec(input vec_t v, input string tag);
      int w, bv_tick, res_tick;
      logic [BW-1:0] board_seen;
      logic wtm_seen, to_seen, ins_seen, clr_seen;
      logic [NR-1:0] oh_seen;
      logic [31:0] mg_seen, eg_seen, cnt_seen;
      w = 0; bv_tick = -1; res_tick = -1;
      board_seen = '0; wtm_seen = 0; to_seen = 0; ins_seen = 0; clr_seen = 0;
      oh_seen = '0; mg_seen = '0; eg_seen = '0; cnt_seen = '0;
      for (int i = 0; i < NR; i++) if (v.exp_oh[i]) w = i;
      stub_lat = v.lat;
      stub_fixed = 1'b1;
      for (int i = 0; i < NR; i++) req_board[i*BW +: BW] = dir_board(i);
      req_white_to_move = 4'b0101;
      req = v.mask;
      for (int t = 1; t <= 100 && res_tick < 0; t++) begin
         tick();
         if (ev_board_valid && bv_tick < 0) begin
            bv_tick = t; board_seen = ev_board; wtm_seen = ev_white_to_move;
         end
         if (result_valid != '0) begin
            res_tick = t; oh_seen = result_valid; mg_seen = result_mg; eg_seen = result_eg;
            ins_seen = result_insufficient; to_seen = result_timeout; clr_seen = ev_clear_eval;
            cnt_seen = eval_count;
         end
      end
      if (!v.exp_to) exp_cnt++;
      check({tag, "_bv_tick"}, 32'(bv_tick), 32'd1);
      check({tag, "_ev_board"}, 32'(board_seen), 32'(dir_board(w)));
      check({tag, "_ev_wtm"}, 32'(wtm_seen), 32'(w % 2 == 0));
      check({tag, "_onehot"}, 32'(oh_seen), 32'(v.exp_oh));
      check({tag, "_res_tick"}, 32'(res_tick), 32'(v.exp_tick));
      check({tag, "_timeout"}, 32'(to_seen), 32'(v.exp_to));
      check({tag, "_mg"}, mg_seen, v.exp_to ? 32'd0 : 32'd100);
      check({tag, "_eg"}, eg_seen, v.exp_to ? 32'd0 : 32'(-50));
      check({tag, "_insuf"}, 32'(ins_seen), 32'd0);
      check({tag, "_clear"}, 32'(clr_seen), 32'd1);
      check({tag, "_count"}, cnt_seen, 32'(exp_cnt));
      req = '0;
      tick();
      tick();
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
   endtask

   // Randomized run: agents and transaction-level model.
   bit            pending [NR];
   int            drop    [NR];
   logic [BW-1:0] brd     [NR];

   initial begin
      int n_bv, n_res, res_at, late_seen;
      int L, m_idle, exp_bv, exp_res, m_win, m_rr, m_cnt, b;
      logic [BW-1:0] m_board;
      logic m_wtm;
      logic [NR-1:0] exp_oh;

      tbl[0] = '{4'b0010, 7,  4'b0010, 9,  1'b0};
      tbl[1] = '{4'b0011, 3,  4'b0001, 5,  1'b0};
      tbl[2] = '{4'b1100, 12, 4'b0100, 14, 1'b0};
      tbl[3] = '{4'b1111, 2,  4'b1000, 4,  1'b0};
      tbl[4] = '{4'b1010, 0,  4'b0010, 66, 1'b1};
      tbl[5] = '{4'b0001, 64, 4'b0001, 66, 1'b0};
      tbl[6] = '{4'b0101, 65, 4'b0100, 66, 1'b1};
      tbl[7] = '{4'b1001, 1,  4'b1000, 3,  1'b0};

      reset = 1'b1; req = '0; req_board = '0; req_white_to_move = '0;
      tick(); tick();
      check_zero_outputs("reset");
      reset = 1'b0;
      tick();

      for (int k = 0; k < 8; k++) run_vec(tbl[k], $sformatf("vec%0d", k));

      // A request still held after its result must not be served again.
      stub_lat = 7; req = 4'b0100; res_at = -1;
      for (int t = 1; t <= 50 && res_at < 0; t++) begin
         tick();
         if (result_valid != '0) res_at = t;
      end
      exp_cnt++;
      check("hold_first_tick", 32'(res_at), 32'd9);
      n_bv = 0;
      for (int t = 0; t < 20; t++) begin
         tick();
         if (ev_board_valid || busy) n_bv++;
      end
      check("hold_no_regrant", 32'(n_bv), 32'd0);
      req = '0; tick();
      req = 4'b0100; n_bv = -1;
      for (int t = 1; t <= 5 && n_bv < 0; t++) begin
         tick();
         if (ev_board_valid) n_bv = t;
      end
      check("rearm_bv_tick", 32'(n_bv), 32'd1);
      res_at = -1;
      for (int t = 1; t <= 50 && res_at < 0; t++) begin
         tick();
         if (result_valid != '0) begin
            res_at = t;
            check("rearm_onehot", 32'(result_valid), 32'b0100);
         end
      end
      exp_cnt++;
      check("rearm_count", eval_count, 32'(exp_cnt));
      req = '0; tick(); tick();

      // Reset in the middle of WAIT; the stale evaluator valid must be ignored.
      stub_lat = 7; req = 4'b0001;
      for (int t = 1; t <= 5; t++) tick();
      check("mid_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0; req = '0;
      check_zero_outputs("midrst");
      n_res = 0; late_seen = 0;
      for (int t = 0; t < 8; t++) begin
         tick();
         if (result_valid != '0 || busy || ev_clear_eval) n_res++;
      end
      check("late_valid_ignored", 32'(n_res), 32'd0);
      stub_kill = 1'b1; tick(); stub_kill = 1'b0; tick();
      exp_cnt = 0;
      run_vec('{4'b1000, 7, 4'b1000, 9, 1'b0}, "postrst");

      // Randomized multi-requester traffic.
      reset = 1'b1; req = '0; tick(); tick(); reset = 1'b0;
      stub_fixed = 1'b0;
      L = int'($urandom_range(2, 12));
      stub_lat = L;
      for (int i = 0; i < NR; i++) begin
         pending[i] = 1'b0; drop[i] = int'($urandom_range(1, 6)); brd[i] = '0;
      end
      m_idle = 0; exp_bv = -1; exp_res = -1; m_win = 0; m_rr = 0; m_cnt = 0;
      m_board = '0; m_wtm = 1'b0;
      for (int t = 1; t <= 800; t++) begin
         tick();
         check("rnd_bv", 32'(ev_board_valid), 32'(t == exp_bv));
         if (t == exp_bv) begin
            check("rnd_ev_board", 32'(ev_board), 32'(m_board));
            check("rnd_ev_wtm", 32'(ev_white_to_move), 32'(m_wtm));
         end
         exp_oh = (t == exp_res) ? NR'(1 << m_win) : '0;
         check("rnd_result_valid", 32'(result_valid), 32'(exp_oh));
         if (t == exp_res) begin
            m_cnt++;
            b = int'({16'd0, m_board});
            check("rnd_mg", result_mg, 32'(b - 30000));
            check("rnd_eg", result_eg, 32'(0 - b));
            check("rnd_insuf", 32'(result_insufficient), 32'(m_board[0]));
            check("rnd_timeout", 32'(result_timeout), 32'd0);
            check("rnd_count", eval_count, 32'(m_cnt));
         end
         for (int i = 0; i < NR; i++) begin
            if (t == exp_res && i == m_win) begin
               pending[i] = 1'b0; req[i] = 1'b0; drop[i] = int'($urandom_range(1, 8));
            end else if (!pending[i]) begin
               if (drop[i] > 1) drop[i]--;
               else begin
                  pending[i] = 1'b1;
                  brd[i] = BW'($urandom);
                  req_board[i*BW +: BW] = brd[i];
                  req_white_to_move[i] = 1'($urandom);
                  req[i] = 1'b1;
               end
            end
         end
         if (t >= m_idle) begin
            for (int k = NR - 1; k >= 0; k--) begin
               if (pending[(m_rr + k) % NR]) begin
                  m_win = (m_rr + k) % NR;
                  exp_bv = -2;
               end
            end
            if (exp_bv == -2) begin
               exp_bv  = t + 1;
               exp_res = t + L + 2;
               m_idle  = t + L + 3;
               m_board = brd[m_win];
               m_wtm   = req_white_to_move[m_win];
               m_rr    = (m_win + 1) % NR;
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
